// File: rtl/ex_ctrl.sv
// ex_ctrl -- execute-stage control and scheduling for the 16-bit pipelined core.
//
// Owns the ID/EX control register: decodes the ID opcode into ALU controls and
// registers the operand-forwarding selects alongside it. Detects load-use and
// flag-use hazards (stall ID, bubble EX), holds the architectural NZV flags and
// sequences HLT through the pipeline.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   id_valid, id_opcode       ID instruction present / its opcode
//   id_rs, id_rt, id_rd       ID register indices
//   id_uses_rs, id_uses_rt    ID instruction reads rs / rt
//   id_flush                  kill the ID instruction (taken branch)
//   mem_stall                 freeze the whole pipeline (cache miss)
//   alu_flags                 {n,z,v} produced for the EX instruction
//   ex_valid                  EX slot holds a real instruction
//   alu_op, alu_src1/2        execute ALU controls
//   fwd_sel_rs/rt             0 = regfile, 1 = EX/MEM result, 2 = MEM/WB result
//   stall_id                  hold PC and IF/ID this cycle (combinational)
//   flags                     architectural {n,z,v}
//   halted                    core has halted
module ex_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [3:0] id_opcode,
  input  logic [3:0] id_rs,
  input  logic [3:0] id_rt,
  input  logic [3:0] id_rd,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_flush,
  input  logic       mem_stall,
  input  logic [2:0] alu_flags,
  output logic       ex_valid,
  output logic [3:0] alu_op,
  output logic       alu_src1,
  output logic       alu_src2,
  output logic [1:0] fwd_sel_rs,
  output logic [1:0] fwd_sel_rt,
  output logic       stall_id,
  output logic [2:0] flags,
  output logic       halted
);

  localparam logic [3:0] OP_B     = 4'b1100;
  localparam logic [3:0] OP_BR    = 4'b1101;
  localparam logic [3:0] ALU_PASS = 4'd13;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       src1;
    logic       src2;
    logic       wr;
    logic [2:0] fmask;
    logic       load;
    logic       hlt;
  } dec_t;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALTED
  } state_t;

  function automatic dec_t decode(input logic [3:0] opc);
    dec_t d;
    d        = '0;
    d.alu_op = ALU_PASS;
    case (opc)
      4'b0000: begin d.alu_op = 4'd0;  d.wr = 1'b1; d.fmask = 3'b111; end
      4'b0001: begin d.alu_op = 4'd1;  d.wr = 1'b1; d.fmask = 3'b111; end
      4'b0010: begin d.alu_op = 4'd2;  d.wr = 1'b1; d.fmask = 3'b010; end
      4'b0011: begin d.alu_op = 4'd8;  d.wr = 1'b1; end
      4'b0100: begin d.alu_op = 4'd3;  d.src2 = 1'b1; d.wr = 1'b1; d.fmask = 3'b010; end
      4'b0101: begin d.alu_op = 4'd4;  d.src2 = 1'b1; d.wr = 1'b1; d.fmask = 3'b010; end
      4'b0110: begin d.alu_op = 4'd5;  d.src2 = 1'b1; d.wr = 1'b1; d.fmask = 3'b010; end
      4'b0111: begin d.alu_op = 4'd9;  d.wr = 1'b1; end
      4'b1000: begin d.alu_op = 4'd10; d.src2 = 1'b1; d.wr = 1'b1; d.load = 1'b1; end
      4'b1001: begin d.alu_op = 4'd10; d.src2 = 1'b1; end
      4'b1010: begin d.alu_op = 4'd11; d.wr = 1'b1; end
      4'b1011: begin d.alu_op = 4'd12; d.wr = 1'b1; end
      4'b1110: begin d.src1 = 1'b1; d.wr = 1'b1; end
      4'b1111: begin d.hlt = 1'b1; end
      default: ;  // B / BR: pass-through op, no writeback, no flags
    endcase
    return d;
  endfunction

  // Nearest producer wins; register 0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic used, input logic [3:0] src,
                                         input logic ex_wr, input logic [3:0] ex_rd,
                                         input logic mem_wr, input logic [3:0] mem_rd);
    if (!used || src == 4'd0) return 2'd0;
    if (ex_wr && ex_rd == src) return 2'd1;
    if (mem_wr && mem_rd == src) return 2'd2;
    return 2'd0;
  endfunction

  state_t     state_q, state_d;
  dec_t       dec_p0;
  logic       load_use_p0, flag_use_p0, hazard_p0, capture_p0;
  logic [1:0] fwd_rs_p0, fwd_rt_p0;

  logic       vld_p1, src1_p1, src2_p1, wr_p1, load_p1, hlt_p1;
  logic [3:0] alu_op_p1, rd_p1;
  logic [1:0] fwd_rs_p1, fwd_rt_p1;
  logic [2:0] fmask_p1;

  logic       vld_p2, wr_p2, hlt_p2;
  logic [3:0] rd_p2;

  logic [2:0] flags_q;

  // ---- p0: ID-side decode, hazard detection, forwarding selection ----
  always_comb begin
    dec_p0      = decode(id_opcode);
    load_use_p0 = vld_p1 && load_p1 && (rd_p1 != 4'd0) &&
                  ((id_uses_rs && id_rs == rd_p1) || (id_uses_rt && id_rt == rd_p1));
    flag_use_p0 = (id_opcode == OP_B || id_opcode == OP_BR) && vld_p1 && (fmask_p1 != 3'b000);
    hazard_p0   = id_valid && (load_use_p0 || flag_use_p0);
    // Flush, hazard and any non-RUN state all turn the capture into a bubble.
    capture_p0  = id_valid && !id_flush && !hazard_p0 && (state_q == S_RUN);
    fwd_rs_p0   = fwd_sel(id_uses_rs, id_rs, vld_p1 && wr_p1, rd_p1, vld_p2 && wr_p2, rd_p2);
    fwd_rt_p0   = fwd_sel(id_uses_rt, id_rt, vld_p1 && wr_p1, rd_p1, vld_p2 && wr_p2, rd_p2);
  end

  always_comb begin
    state_d  = state_q;
    halted   = 1'b0;
    stall_id = mem_stall || hazard_p0 || (state_q != S_RUN);
    case (state_q)
      S_RUN:    if (capture_p0 && dec_p0.hlt) state_d = S_DRAIN;
      // HLT leaving MEM on this edge is the moment it reaches WB.
      S_DRAIN:  if (hlt_p2) state_d = S_HALTED;
      S_HALTED: halted = 1'b1;
      default:  state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
    end else if (!mem_stall) begin
      state_q <= state_d;
    end
  end

  // ---- p1: ID/EX register (EX tracker entry); p2: MEM tracker entry ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      alu_op_p1 <= ALU_PASS;
      src1_p1   <= 1'b0;
      src2_p1   <= 1'b0;
      fwd_rs_p1 <= 2'd0;
      fwd_rt_p1 <= 2'd0;
      wr_p1     <= 1'b0;
      rd_p1     <= 4'd0;
      load_p1   <= 1'b0;
      fmask_p1  <= 3'b000;
      hlt_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      wr_p2     <= 1'b0;
      rd_p2     <= 4'd0;
      hlt_p2    <= 1'b0;
      flags_q   <= 3'b000;
    end else if (!mem_stall) begin
      if (vld_p1) flags_q <= (flags_q & ~fmask_p1) | (alu_flags & fmask_p1);
      vld_p2    <= vld_p1;
      wr_p2     <= wr_p1;
      rd_p2     <= rd_p1;
      hlt_p2    <= hlt_p1;
      vld_p1    <= capture_p0;
      alu_op_p1 <= capture_p0 ? dec_p0.alu_op : ALU_PASS;
      src1_p1   <= capture_p0 && dec_p0.src1;
      src2_p1   <= capture_p0 && dec_p0.src2;
      fwd_rs_p1 <= capture_p0 ? fwd_rs_p0 : 2'd0;
      fwd_rt_p1 <= capture_p0 ? fwd_rt_p0 : 2'd0;
      wr_p1     <= capture_p0 && dec_p0.wr;
      rd_p1     <= capture_p0 ? id_rd : 4'd0;
      load_p1   <= capture_p0 && dec_p0.load;
      fmask_p1  <= capture_p0 ? dec_p0.fmask : 3'b000;
      hlt_p1    <= capture_p0 && dec_p0.hlt;
    end
  end

  assign ex_valid   = vld_p1;
  assign alu_op     = alu_op_p1;
  assign alu_src1   = src1_p1;
  assign alu_src2   = src2_p1;
  assign fwd_sel_rs = fwd_rs_p1;
  assign fwd_sel_rt = fwd_rt_p1;
  assign flags      = flags_q;

endmodule

// File: tb/tb_ex_ctrl.sv
// tb_ex_ctrl -- directed self-checking bench for ex_ctrl.
// An instruction-level pipeline model (EX/MEM/WB slots of decoded records, a
// decode lookup table and a flag word) predicts every output each cycle; a few
// hand-computed literal checks pin the model to the expected behaviour.
module tb_ex_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_opcode, id_rs, id_rt, id_rd;
  logic       id_uses_rs, id_uses_rt, id_flush, mem_stall;
  logic [2:0] alu_flags;
  logic       ex_valid, alu_src1, alu_src2, stall_id, halted;
  logic [3:0] alu_op;
  logic [1:0] fwd_sel_rs, fwd_sel_rt;
  logic [2:0] flags;

  always #5 clk = ~clk;

  ex_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_flush(id_flush),
    .mem_stall(mem_stall), .alu_flags(alu_flags),
    .ex_valid(ex_valid), .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .fwd_sel_rs(fwd_sel_rs), .fwd_sel_rt(fwd_sel_rt), .stall_id(stall_id),
    .flags(flags), .halted(halted)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    bit       v, wr, ld, hl, s1, s2;
    bit [3:0] rd;
    bit [2:0] fm;
    bit [3:0] op;
    bit [1:0] f1, f2;
  } ent_t;

  int t_op [16] = '{0, 1, 2, 8, 3, 4, 5, 9, 10, 10, 11, 12, 13, 13, 13, 13};
  int t_s1 [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
  int t_s2 [16] = '{0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0};
  int t_wr [16] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 0, 0, 1, 0};
  int t_fm [16] = '{7, 7, 2, 0, 2, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  ent_t     m_ex, m_mem, m_wb, m_new;
  bit [2:0] m_flags;
  bit       m_drain, m_halted;
  int       o;

  function automatic ent_t empty_slot();
    ent_t z;
    z    = '0;
    z.op = 4'd13;
    return z;
  endfunction

  function automatic bit m_hazard();
    if (!id_valid) return 1'b0;
    if (m_ex.v && m_ex.ld && m_ex.rd != 0 &&
        ((id_uses_rs && id_rs == m_ex.rd) || (id_uses_rt && id_rt == m_ex.rd))) return 1'b1;
    if ((id_opcode == 4'd12 || id_opcode == 4'd13) && m_ex.v && m_ex.fm != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit [1:0] m_fwd(input bit [3:0] r, input bit use_it);
    if (!use_it || r == 0) return 2'd0;
    if (m_ex.v && m_ex.wr && m_ex.rd == r) return 2'd1;
    if (m_mem.v && m_mem.wr && m_mem.rd == r) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_ex = empty_slot(); m_mem = empty_slot(); m_wb = empty_slot();
      m_flags = 3'b000; m_drain = 1'b0; m_halted = 1'b0;
    end else if (!mem_stall) begin
      m_new = empty_slot();
      if (id_valid && !id_flush && !m_hazard() && !m_drain && !m_halted) begin
        o        = int'(id_opcode);
        m_new.v  = 1'b1;
        m_new.op = 4'(t_op[o]);
        m_new.s1 = t_s1[o] != 0;
        m_new.s2 = t_s2[o] != 0;
        m_new.wr = t_wr[o] != 0;
        m_new.fm = 3'(t_fm[o]);
        m_new.ld = (o == 8);
        m_new.hl = (o == 15);
        m_new.rd = id_rd;
        m_new.f1 = m_fwd(id_rs, id_uses_rs);
        m_new.f2 = m_fwd(id_rt, id_uses_rt);
      end
      if (m_ex.v) m_flags = (m_flags & ~m_ex.fm) | (alu_flags & m_ex.fm);
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = m_new;
      if (m_ex.hl) m_drain = 1'b1;
      if (m_wb.hl) begin m_halted = 1'b1; m_drain = 1'b0; end
    end
  endtask

  // Model advances on the active edge; outputs are compared on the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (chk_en) begin
        chk("m_ex_valid", ex_valid, m_ex.v);
        chk("m_alu_op", alu_op, m_ex.op);
        chk("m_src1", alu_src1, m_ex.s1);
        chk("m_src2", alu_src2, m_ex.s2);
        chk("m_fwd_rs", fwd_sel_rs, m_ex.f1);
        chk("m_fwd_rt", fwd_sel_rt, m_ex.f2);
        chk("m_flags", flags, m_flags);
        chk("m_halted", halted, m_halted);
        chk("m_stall", stall_id, mem_stall || m_drain || m_halted || m_hazard());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic put(input int op, input int rd, input int rs, input int rt,
                     input bit urs, input bit urt);
    id_valid   = 1'b1;
    id_opcode  = 4'(op);
    id_rd      = 4'(rd);
    id_rs      = 4'(rs);
    id_rt      = 4'(rt);
    id_uses_rs = urs;
    id_uses_rt = urt;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_opcode = 4'd0; id_rd = 4'd0; id_rs = 4'd0; id_rt = 4'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0;
  endtask

  task automatic mid(); @(negedge clk); #1; endtask
  task automatic nxt(); @(posedge clk); #1; endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; id_flush = 1'b0; mem_stall = 1'b0; alu_flags = 3'b000;
    idle();
    nxt(); nxt();
    chk_en = 1'b1;
    mid();
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_alu_op", alu_op, 13);
    chk("rst_src", {alu_src1, alu_src2}, 0);
    chk("rst_fwd", {fwd_sel_rs, fwd_sel_rt}, 0);
    chk("rst_flags", flags, 0);
    chk("rst_halted", halted, 0);
    rst = 1'b0;
    nxt();

    // ADD r1 = r2 + r3, then SUB r2 = r1 - r3
    put(0, 1, 2, 3, 1, 1); mid(); chk("add_stall", stall_id, 0); nxt();
    put(1, 2, 1, 3, 1, 1); alu_flags = 3'b010;
    mid(); chk("add_ex", ex_valid, 1); chk("add_op", alu_op, 0); nxt();
    put(3, 6, 1, 3, 1, 1); alu_flags = 3'b011;
    mid(); chk("sub_fwd_rs", fwd_sel_rs, 1); chk("sub_fwd_rt", fwd_sel_rt, 0);
    chk("sub_op", alu_op, 1); chk("add_flags", flags, 3'b010); nxt();
    put(2, 7, 8, 9, 1, 1); alu_flags = 3'b111;
    mid(); chk("red_fwd_rs", fwd_sel_rs, 2); chk("red_fwd_rt", fwd_sel_rt, 0);
    chk("sub_flags", flags, 3'b011); nxt();
    // XOR with alu_flags 101 writes only Z
    put(7, 8, 9, 10, 1, 1); alu_flags = 3'b101;
    mid(); chk("red_flags_hold", flags, 3'b011); nxt();
    put(8, 4, 2, 0, 1, 0); alu_flags = 3'b110;
    mid(); chk("xor_flags", flags, 3'b001); nxt();
    // LW r4 then XOR r5 = r4 ^ r4: load-use
    put(2, 5, 4, 4, 1, 1); alu_flags = 3'b000;
    mid(); chk("lu_stall", stall_id, 1); chk("paddsb_flags", flags, 3'b001); nxt();
    mid(); chk("lu_bubble_v", ex_valid, 0); chk("lu_bubble_op", alu_op, 13);
    chk("lu_stall_end", stall_id, 0); nxt();
    put(1, 3, 5, 1, 1, 1); alu_flags = 3'b010;
    mid(); chk("lu_ex", ex_valid, 1); chk("lu_fwd_rs", fwd_sel_rs, 2); chk("lu_fwd_rt", fwd_sel_rt, 2); nxt();
    // SUB then B: flag hazard
    put(12, 0, 0, 0, 0, 0); alu_flags = 3'b100;
    mid(); chk("sb_fwd_rs", fwd_sel_rs, 1); chk("fh_stall", stall_id, 1); chk("fh_flags_pre", flags, 3'b011); nxt();
    alu_flags = 3'b000;
    mid(); chk("fh_bubble", ex_valid, 0); chk("fh_stall_end", stall_id, 0); chk("fh_flags", flags, 3'b100); nxt();
    put(0, 9, 1, 2, 1, 1);
    mid(); chk("b_ex", ex_valid, 1); chk("b_op", alu_op, 13); nxt();
    // mem_stall for 3 cycles with a flag-setting ADD in EX
    put(4, 10, 9, 0, 1, 0); mem_stall = 1'b1; alu_flags = 3'b111;
    mid(); chk("ms_stall0", stall_id, 1); nxt();
    mid(); chk("ms_stall1", stall_id, 1); nxt();
    mid(); chk("ms_flags", flags, 3'b100); chk("ms_op", alu_op, 0); chk("ms_ex", ex_valid, 1);
    chk("ms_stall2", stall_id, 1); nxt();
    mem_stall = 1'b0; alu_flags = 3'b001;
    mid(); chk("ms_resume_stall", stall_id, 0); nxt();
    // flush
    put(10, 11, 0, 0, 0, 0); id_flush = 1'b1; alu_flags = 3'b000;
    mid(); chk("sll_fwd", fwd_sel_rs, 1); chk("sll_op", alu_op, 3); chk("sll_src2", alu_src2, 1);
    chk("ms_flags_after", flags, 3'b001); nxt();
    id_flush = 1'b0; put(8, 12, 1, 0, 1, 0);
    mid(); chk("flush_bubble", ex_valid, 0); nxt();
    // flush during a load-use stall
    put(6, 13, 12, 0, 1, 0); id_flush = 1'b1;
    mid(); chk("flush_lu_stall", stall_id, 1); nxt();
    id_flush = 1'b0; put(14, 14, 0, 0, 0, 0);
    mid(); chk("flush_lu_bubble", ex_valid, 0); nxt();
    idle();
    mid(); chk("pcs_src1", alu_src1, 1); chk("pcs_op", alu_op, 13); chk("pcs_ex", ex_valid, 1); nxt();

    // decode sweep, each opcode separated by an empty ID slot
    for (int op = 0; op < 15; op++) begin
      put(op, (op % 7) + 1, ((op + 6) % 7) + 1, op, 1, 1);
      alu_flags = 3'(op);
      mid(); nxt();
      idle();
      mid(); nxt();
    end

    // HLT
    put(15, 0, 0, 0, 0, 0);
    mid(); chk("hlt_stall_pre", stall_id, 0); nxt();
    put(0, 1, 2, 3, 1, 1);
    mid(); chk("drain_stall", stall_id, 1); chk("drain_halted", halted, 0); chk("hlt_ex", ex_valid, 1); nxt();
    mid(); chk("drain2_halted", halted, 0); chk("drain2_bubble", ex_valid, 0); nxt();
    mid(); chk("halted_set", halted, 1); chk("halted_stall", stall_id, 1); nxt();
    mid(); chk("halted_stays", halted, 1); nxt();
    rst = 1'b1;
    mid(); nxt();
    rst = 1'b0;
    mid(); chk("rst2_halted", halted, 0); chk("rst2_flags", flags, 0); chk("rst2_ex", ex_valid, 0);
    chk("rst2_op", alu_op, 13); chk("rst2_stall", stall_id, 0); nxt();
    put(15, 0, 0, 0, 0, 0);
    mid(); chk("post_rst_add", ex_valid, 1); chk("post_rst_op", alu_op, 0); nxt();
    put(0, 1, 2, 3, 1, 1);
    mid(); chk("drain_again", stall_id, 1); rst = 1'b1; nxt();
    rst = 1'b0;
    mid(); chk("rst_drain_stall", stall_id, 0); chk("rst_drain_halted", halted, 0); chk("rst_drain_ex", ex_valid, 0); nxt();
    mid(); chk("rst_drain_resume", ex_valid, 1); nxt();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_ctrl.md
# ex_ctrl

Control and scheduling block for the execute stage of the 16-bit pipelined core. Owns the ID/EX control register: decodes the ID opcode into the execute-stage ALU controls and registers the operand-forwarding selects. Detects load-use and flag-use hazards and issues stalls and bubbles. Holds the architectural NZV flag register and the halt sequencer.

## Interface
Parameters:
- none; widths are fixed by the ISA (4-bit opcode, 4-bit register index).

Ports:
- clk  in  1  rising-edge clock; single clock domain
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  a valid instruction is present in ID
- id_opcode  in  4  ISA opcode of the ID instruction
- id_rs, id_rt, id_rd  in  4 each  ID source and destination indices
- id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt
- id_flush  in  1  taken branch; kill the ID instruction
- mem_stall  in  1  cache miss; freeze the whole pipeline
- alu_flags  in  3  {n,z,v} from the execute datapath for the EX instruction
- ex_valid  out  1  EX slot holds a real instruction
- alu_op  out  4  execute ALU operation code
- alu_src1  out  1  1 = pc_plus2, 0 = rs
- alu_src2  out  1  1 = imm, 0 = rt
- fwd_sel_rs, fwd_sel_rt  out  2 each  0 = register file, 1 = EX/MEM result, 2 = MEM/WB result
- stall_id  out  1  hold PC and IF/ID this cycle (combinational)
- flags  out  3  architectural {n,z,v}
- halted  out  1  core has halted

## Operation
- Decode (opcode -> alu_op, src1, src2, writes rd, sets flags):
  - ADD 0000 -> 0, 0, 0, wr, NZV
  - SUB 0001 -> 1, 0, 0, wr, NZV
  - XOR 0010 -> 2, wr, Z
  - RED 0011 -> 8, wr
  - SLL 0100 -> 3, src2 = 1, wr, Z
  - SRA 0101 -> 4, src2 = 1, wr, Z
  - ROR 0110 -> 5, src2 = 1, wr, Z
  - PADDSB 0111 -> 9, wr
  - LW 1000 -> 10, src2 = 1, wr, load
  - SW 1001 -> 10, src2 = 1
  - LLB 1010 -> 11, wr
  - LHB 1011 -> 12, wr
  - B 1100 / BR 1101 -> 13
  - PCS 1110 -> 13, src1 = 1, wr
  - HLT 1111 -> 13, halt
  - src1 and src2 are 0 wherever not listed.
- Destination tracker: three stages (EX, MEM, WB), each holding {valid, wr, rd, load}.
  - Entries advance every non-frozen cycle.
  - A bubble inserts an all-zero entry.
  - rd = 0 is never a forwarding or hazard source.
- Forwarding selects are computed from the ID instruction and registered into EX together with the decode.
  - The EX entry at capture time (becoming MEM) gives select 1.
  - The MEM entry (becoming WB) gives select 2.
  - The nearest producer wins: 1 takes priority over 2.
  - A select is 0 when the matching use bit is clear.
- Load-use hazard: the EX entry is a valid load, its rd is nonzero, and it equals a used ID source.
  - Assert stall_id.
  - Insert a bubble into EX (ex_valid = 0, alu_op = 13, tracker entry zeroed).
- Flag hazard: an ID B/BR while the EX instruction sets any flag. Same stall and bubble.
- Flag register:
  - Updates at the end of a cycle in which ex_valid = 1 and mem_stall = 0.
  - Written bits follow the per-opcode mask; all other bits hold.
- Halt FSM: RUN -> DRAIN when HLT is captured into EX; DRAIN -> HALTED when HLT reaches WB.
  - In DRAIN and HALTED, stall_id = 1 and every new EX entry is a bubble.
  - halted = 1 only in HALTED.
  - HALTED is left only by reset.
- id_flush: the captured entry is a bubble, whatever the ID contents.

## Timing
- Decode, forwarding, and tracker are registered: they appear on the outputs the cycle after ID capture.
- stall_id is combinational from the current ID inputs and the EX entry.
- mem_stall = 1 freezes everything: ID/EX register, tracker, flags, and FSM hold. stall_id = 1.
- Priority: rst > mem_stall > id_flush > hazard stall > normal capture.
- Flush during a hazard stall produces a bubble, and stall_id still asserts.
- Reset state, all outputs:
  - ex_valid = 0, alu_op = 13, alu_src1 = 0, alu_src2 = 0
  - fwd_sel_rs = fwd_sel_rt = 0
  - flags = 000, halted = 0, FSM = RUN, tracker cleared
- Reset mid-stall or in DRAIN returns to RUN within one cycle.

## Test plan
- ADD r1 then SUB r2 = r1 - r3, back-to-back: SUB enters EX with fwd_sel_rs = 1, fwd_sel_rt = 0. One instruction later the selects are 2 and 0. With alu_flags = 3'b010 on the ADD, flags = 010 after ADD's EX cycle.
- LW r4 followed by XOR r5 = r4 ^ r4: stall_id = 1 for one cycle and one bubble enters EX (ex_valid = 0). XOR then enters with fwd_sel_rs = fwd_sel_rt = 2.
- XOR with alu_flags = 3'b101 after flags = 011: flags becomes 001 (only Z written). A following PADDSB leaves flags unchanged.
- SUB then B: one-cycle stall; B enters EX after the SUB flags have been written.
- mem_stall held high for 3 cycles mid-stream: outputs and flags are unchanged and stall_id = 1 throughout. Operation resumes exactly where it stopped.
- HLT: halted = 1 two cycles after HLT's EX cycle and stays 1. Pulsing rst clears halted, flags, and ex_valid on the next edge.
